// File: rtl/bioz_clkgen_div_if.sv
// Control and clock-output bundle of the BioZ clock generator.
// The master side drives the run request and divide select, the slave side returns clocks and status.
interface bioz_clkgen_div_if #(
  parameter int FSEL_W = 4
);
  logic              enable;
  logic [FSEL_W-1:0] Fsel;
  logic              clk_SigGen;
  logic              clk_ADC;
  logic              clk_IF;
  logic              clk_PM;
  logic [FSEL_W-1:0] fsel_active;
  logic              pm_active;
  logic              running;

  modport master (
    output enable, Fsel,
    input  clk_SigGen, clk_ADC, clk_IF, clk_PM, fsel_active, pm_active, running
  );

  modport slave (
    input  enable, Fsel,
    output clk_SigGen, clk_ADC, clk_IF, clk_PM, fsel_active, pm_active, running
  );
endinterface

// File: rtl/bioz_clkgen_div.sv
// BioZ clock generator: three glitch-free start/stop divider channels (SigGen, ADC, IF)
// plus a phase-accumulator NCO producing clk_PM at f_SigGen - f_IF.

module bioz_clkgen_div_chan #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [CW-1:0] last,
  input  logic [CW-1:0] half,
  output logic          out,
  output logic          busy,
  output logic          busy_next,
  output logic          wrap
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_adv;
  logic          hi_adv;
  logic          out_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      out   <= out_next;
    end
  end

  // A stop request only ends the channel once the next cycle would be low,
  // so a wrap coinciding with enable falling still yields a full high phase.
  always_comb begin
    wrap       = (state != IDLE) && (cnt == last);
    cnt_adv    = wrap ? '0 : cnt + 1'b1;
    hi_adv     = cnt_adv < half;
    state_next = state;
    cnt_next   = '0;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      default: begin
        if (enable) begin
          state_next = RUN;
          cnt_next   = cnt_adv;
        end else if (hi_adv) begin
          state_next = STOPPING;
          cnt_next   = cnt_adv;
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    out_next  = (state_next != IDLE) && (cnt_next < half);
    busy      = state != IDLE;
    busy_next = state_next != IDLE;
  end
endmodule

module bioz_clkgen_div #(
  parameter int FSEL_W   = 4,
  parameter int ADC_DIV  = 426,
  parameter int IF_DIV   = 2048,
  parameter int ACC_W    = 24,
  parameter int RST_FSEL = 10
) (
  input logic              clk,
  input logic              rst,
  bioz_clkgen_div_if.slave bus
);
  localparam int                SIG_CW     = 2**FSEL_W + 1;
  localparam int                ADC_CW     = $clog2(ADC_DIV);
  localparam int                IF_CW      = $clog2(IF_DIV);
  localparam logic [FSEL_W-1:0] RST_FSEL_V = FSEL_W'(RST_FSEL);
  localparam logic [ACC_W:0]    ACC_ONE    = {{ACC_W{1'b0}}, 1'b1};
  localparam logic [ACC_W:0]    IF_TW      = (ACC_ONE << ACC_W) / (ACC_W+1)'(IF_DIV);

  logic [FSEL_W-1:0]     fsel_active;
  logic signed [ACC_W:0] tw_pm, tw_now, tw_rst;
  logic                  pm_active;
  logic                  running;
  logic [ACC_W-1:0]      acc;
  logic [SIG_CW-1:0]     sig_half, sig_last;
  logic                  sig_out, sig_busy, sig_busy_next, sig_wrap;
  logic                  adc_out, adc_busy, adc_busy_next, adc_wrap;
  logic                  if_out, if_busy, if_busy_next, if_wrap;
  logic                  unused_ok;

  function automatic logic signed [ACC_W:0] calc_tw(input logic [FSEL_W-1:0] f);
    logic [ACC_W:0] sig_tw;
    sig_tw = ACC_ONE << (ACC_W - 1 - int'(f));
    return $signed(sig_tw - IF_TW);
  endfunction

  always_comb begin
    sig_half = SIG_CW'(1) << fsel_active;
    sig_last = {sig_half[SIG_CW-2:0], 1'b0} - 1'b1;
    tw_now   = calc_tw(fsel_active);
    tw_rst   = calc_tw(RST_FSEL_V);
  end

  bioz_clkgen_div_chan #(.CW(SIG_CW)) u_sig (
    .clk(clk), .rst(rst), .enable(bus.enable),
    .last(sig_last), .half(sig_half),
    .out(sig_out), .busy(sig_busy), .busy_next(sig_busy_next), .wrap(sig_wrap)
  );

  bioz_clkgen_div_chan #(.CW(ADC_CW)) u_adc (
    .clk(clk), .rst(rst), .enable(bus.enable),
    .last(ADC_CW'(ADC_DIV - 1)), .half(ADC_CW'((ADC_DIV + 1) / 2)),
    .out(adc_out), .busy(adc_busy), .busy_next(adc_busy_next), .wrap(adc_wrap)
  );

  bioz_clkgen_div_chan #(.CW(IF_CW)) u_if (
    .clk(clk), .rst(rst), .enable(bus.enable),
    .last(IF_CW'(IF_DIV - 1)), .half(IF_CW'(IF_DIV / 2)),
    .out(if_out), .busy(if_busy), .busy_next(if_busy_next), .wrap(if_wrap)
  );

  // The divide select only changes on a period boundary, so no period is ever cut or stretched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsel_active <= RST_FSEL_V;
    end else if (!sig_busy || sig_wrap) begin
      fsel_active <= bus.Fsel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw_pm     <= tw_rst;
      pm_active <= tw_rst > 0;
    end else begin
      tw_pm     <= tw_now;
      pm_active <= tw_now > 0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (!sig_busy || !sig_busy_next || !pm_active) begin
      acc <= '0;
    end else begin
      acc <= acc + tw_pm[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else begin
      running <= sig_busy_next | adc_busy_next | if_busy_next;
    end
  end

  assign unused_ok = &{1'b0, adc_busy, adc_wrap, if_busy, if_wrap, tw_pm[ACC_W]};

  assign bus.clk_SigGen  = sig_out;
  assign bus.clk_ADC     = adc_out;
  assign bus.clk_IF      = if_out;
  assign bus.clk_PM      = acc[ACC_W-1];
  assign bus.fsel_active = fsel_active;
  assign bus.pm_active   = pm_active;
  assign bus.running     = running;
endmodule
